fetch_realign_fifo: RTL
=======================

Name: fetch_realign_fifo

Overview:
- Parametrised instruction fetch queue between the I-fetch port and decode.
- Stores fetched 32-bit words as a circular buffer of 16-bit halfwords.
- Realigns mixed RV32C/RV32I streams, including 32-bit instructions that straddle words, and tracks each instruction's PC internally.
- Full valid/ready handshakes on both sides; flush accepts a redirect PC, which may be halfword-aligned.

Parameters:
- DEPTH, 4, buffer capacity in 32-bit words (2*DEPTH halfword slots); legal range 2..16, power of two.
- RESET_PC, 32'h1000_0000, PC of the first word fetched after reset.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all contents; redirect PC
- flush_pc_i  in  32  PC of next instruction after flush; bit 0 ignored
- in_valid_i  in  1  fetched word available
- in_ready_o  out  1  buffer can accept a word
- in_instr_i  in  32  fetched word, always word-aligned
- out_valid_o  out  1  complete instruction at head
- out_ready_i  in  1  decode consumes head instruction
- out_instr_o  out  32  head instruction; compressed instructions zero-extended in [31:16]
- out_pc_o  out  32  PC of head instruction
- out_compressed_o  out  1  head is 16-bit (bits[1:0] != 2'b11)
- count_o  out  $clog2(2*DEPTH)+1  occupied halfword slots

Behaviour:
- Reset (rst_i=1 at clock edge):
  - count=0, rd/wr pointers=0, head PC=RESET_PC, skip flag=0.
  - Outputs: out_valid_o=0, out_instr_o=0, out_compressed_o=0, in_ready_o=1.
- in_ready_o:
  - Equals (2*DEPTH - count >= 2) && !flush_i.
  - Registered-count based only; no same-cycle pop credit.
- Push (in_valid_i && in_ready_o): writes in_instr_i[15:0] at wr_ptr and [31:16] at wr_ptr+1, then wr_ptr += 2.
  - If the skip flag is set, only [31:16] is written, wr_ptr += 1, and skip clears.
- Head decode:
  - h0 = slot[rd_ptr], h1 = slot[rd_ptr+1] (modulo 2*DEPTH).
  - Compressed when h0[1:0] != 2'b11.
  - out_valid_o = (count>=1 && compressed) || (count>=2).
- Head output:
  - Compressed: out_instr_o = {16'h0, h0}.
  - Otherwise: out_instr_o = {h1, h0}.
  - out_instr_o = 0 whenever out_valid_o=0.
- Pop (out_valid_o && out_ready_i): rd_ptr += 1 and PC += 2 if compressed; else rd_ptr += 2 and PC += 4.
- Simultaneous push and pop: both take effect; count_next = count + pushed - popped.
- Pointers wrap modulo 2*DEPTH. Full/empty is determined by count, never by pointer equality.
- Straddling 32-bit instruction with only one halfword present: out_valid_o stays 0 until the next push. No partial output.
- Flush has the highest priority:
  - Ignores push and pop that cycle; in_ready_o=0 and out_valid_o=0 in the flush cycle.
  - Next state: count=0, pointers=0, head PC={flush_pc_i[31:1],1'b0}, skip flag=flush_pc_i[1].
- Reset mid-operation overrides flush and all traffic. No state survives reset.
- Latency: pushed word → out_valid_o the next cycle (without the optional feature).
- PC arithmetic is 32-bit and wraps modulo 2^32 silently.

Optional Feature:
- Macro: FETCH_FIFO_BYPASS_EN.
- Defined: when count==0 and in_valid_i && in_ready_o, the head is assembled combinationally from in_instr_i, honouring skip, so out_valid_o can assert in the same cycle.
  - If popped that cycle, only leftover halfwords are stored: none, or one after a compressed instruction.
  - Adds a combinational in→out path.
- Undefined: no in→out combinational path; minimum latency is 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - HALF_W=16, INSTR_W=32
  - typedef halfword_t
  - function is_compressed(logic [1:0])
  - constant RESET_PC_DEFAULT
- Sub-module rvc_head_align (combinational):
  - Inputs: h0, h1, count, PC.
  - Outputs: instr, compressed, valid, pop size (1 or 2).
  - Reused by the bypass path.

Test Plan:
- Reset then push 32'h0000_0013 (addi) → next cycle out_valid_o=1, out_instr_o=32'h0000_0013, out_pc_o=32'h1000_0000, out_compressed_o=0; pop → count_o=0.
- Push 32'h4501_4505 (two c.li) → two pops: instr 32'h0000_4505 @PC 0x1000_0000, then 32'h0000_4501 @PC 0x1000_0002.
- Straddle: push 32'h0013_4505, hold out_ready_i=1 → after c.li, out_valid_o=0 until push of 32'hxxxx_0000 → instr 32'h0000_0013 @PC 0x1000_0002.
- Fill with DEPTH=4, out_ready_i=0, 4 pushes → count_o=8, in_ready_o=0; one 32-bit pop → in_ready_o=1; wrap-around data intact across 12 pushes.
- Flush with flush_pc_i=32'h2000_0006, then push 32'h4505_ABCD → out_instr_o=32'h0000_4505, out_pc_o=32'h2000_0006, count_o=1.
- Flush and push asserted in the same cycle with full buffer → pushed word dropped, count_o=0 next cycle; rst_i mid-stream → out_pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_realign_fifo_pkg.sv
// Shared types and constants for the instruction fetch realignment queue.
package fetch_pkg;

  localparam int unsigned HALF_W  = 16;
  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1000_0000;

  typedef logic [HALF_W-1:0] halfword_t;

  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/rvc_head_align.sv
// Combinational head decode: forms one RV32C/RV32I instruction from the two
// oldest halfwords and reports how far the read side advances when it is taken.
module rvc_head_align
  import fetch_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  halfword_t            h0,
  input  halfword_t            h1,
  input  logic [CW-1:0]        count,
  input  logic [31:0]          pc,
  output logic [INSTR_W-1:0]   instr,
  output logic                 compressed,
  output logic                 valid,
  output logic [1:0]           pop_size,
  output logic [31:0]          pc_next
);

  logic comp_raw;

  always_comb begin
    comp_raw   = is_compressed(h0[1:0]);
    valid      = (count >= CW'(1) && comp_raw) || (count >= CW'(2));
    compressed = valid && comp_raw;
    pop_size   = comp_raw ? 2'd1 : 2'd2;
    pc_next    = pc + (comp_raw ? 32'd2 : 32'd4);
    instr      = '0;
    if (valid) begin
      instr = comp_raw ? {{HALF_W{1'b0}}, h0} : {h1, h0};
    end
  end

endmodule

// File: rtl/fetch_realign_fifo.sv
// Instruction fetch queue storing words as halfword slots and realigning mixed
// RV32C/RV32I streams. Define FETCH_FIFO_BYPASS_EN for same-cycle empty bypass.
module fetch_realign_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [31:0]                 flush_pc_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [INSTR_W-1:0]          in_instr_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [INSTR_W-1:0]          out_instr_o,
  output logic [31:0]                 out_pc_o,
  output logic                        out_compressed_o,
  output logic [$clog2(2*DEPTH):0]    count_o
);

  localparam int unsigned SLOTS = 2 * DEPTH;
  localparam int unsigned PW    = $clog2(SLOTS);
  localparam int unsigned CW    = PW + 1;

  halfword_t       mem [SLOTS];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW-1:0]   rd_ptr_p1, wr_ptr_p1;
  logic [CW-1:0]   count_q;
  logic [31:0]     pc_q;
  logic            skip_q;

  logic            push, pop;
  logic [CW-1:0]   push_n;
  halfword_t       head_h0, head_h1;
  logic [CW-1:0]   head_count;
  logic [INSTR_W-1:0] head_instr;
  logic            head_valid, head_comp;
  logic [1:0]      pop_size;
  logic [31:0]     pc_next;
  logic            unused_flush_pc_lsb;

  assign unused_flush_pc_lsb = flush_pc_i[0];

  assign rd_ptr_p1 = rd_ptr_q + PW'(1);
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);

  always_comb begin
    in_ready_o = (count_q <= CW'(SLOTS - 2)) && !flush_i;
    push       = in_valid_i && in_ready_o;
    push_n     = skip_q ? CW'(1) : CW'(2);
  end

`ifdef FETCH_FIFO_BYPASS_EN
  // With an empty queue the incoming word is presented directly; it is still
  // written normally, and rd_ptr==wr_ptr means a pop simply skips what was used.
  always_comb begin
    head_h0    = mem[rd_ptr_q];
    head_h1    = mem[rd_ptr_p1];
    head_count = count_q;
    if (count_q == '0 && push) begin
      head_h0    = skip_q ? in_instr_i[31:16] : in_instr_i[15:0];
      head_h1    = skip_q ? '0 : in_instr_i[31:16];
      head_count = push_n;
    end
  end
`else
  always_comb begin
    head_h0    = mem[rd_ptr_q];
    head_h1    = mem[rd_ptr_p1];
    head_count = count_q;
  end
`endif

  rvc_head_align #(
    .CW (CW)
  ) u_align (
    .h0         (head_h0),
    .h1         (head_h1),
    .count      (head_count),
    .pc         (pc_q),
    .instr      (head_instr),
    .compressed (head_comp),
    .valid      (head_valid),
    .pop_size   (pop_size),
    .pc_next    (pc_next)
  );

  always_comb begin
    out_valid_o      = head_valid && !flush_i;
    out_compressed_o = head_comp && !flush_i;
    out_instr_o      = flush_i ? '0 : head_instr;
    out_pc_o         = pc_q;
    count_o          = count_q;
    pop              = out_valid_o && out_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= RESET_PC;
      skip_q   <= 1'b0;
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= {flush_pc_i[31:1], 1'b0};
      skip_q   <= flush_pc_i[1];
    end else begin
      if (push) begin
        wr_ptr_q <= skip_q ? wr_ptr_p1 : wr_ptr_q + PW'(2);
        skip_q   <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(pop_size);
        pc_q     <= pc_next;
      end
      count_q <= count_q + (push ? push_n : '0) - (pop ? CW'(pop_size) : '0);
    end
  end

  // Halfword storage is not reset; count alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      if (skip_q) begin
        mem[wr_ptr_q] <= in_instr_i[31:16];
      end else begin
        mem[wr_ptr_q]  <= in_instr_i[15:0];
        mem[wr_ptr_p1] <= in_instr_i[31:16];
      end
    end
  end

endmodule
